registro_pipeline: RTL

Parametrised N-bit, multi-stage pipeline register with valid/ready handshake, global enable, synchronous flush and occupancy count. It is the successor to the single-stage enabled register used throughout the servo datapath (PWM duty path, ADC sample path). Use it wherever a value must be delayed or retimed by several clocks without losing words when the consumer stalls. Empty stages collapse (bubbles are squeezed out), so a stalled pipe fills to DEPTH words before it backpressures.

---
 rtl/registro_pipeline_if.sv | 22 ++
 rtl/registro_pipeline.sv | 93 +++++++++
 2 files changed

// File: rtl/registro_pipeline_if.sv
// rtl/registro_pipeline_if.sv - valid/ready stream bundle for registro_pipeline
// The master drives the input word and the downstream ready; the slave is the pipeline.
interface registro_pipeline_if #(
    parameter int WIDTH = 23
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/registro_pipeline.sv
// rtl/registro_pipeline.sv - multi-stage pipeline register with bubble collapse
// Each stage advances when it is empty or the stage after it advances, so a stalled pipe fills completely.
module registro_pipeline #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    registro_pipeline_if.slave   bus,
    output logic [CW-1:0]        count
);

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_take;
    logic [DEPTH-1:0] w_src_v;
    logic [WIDTH-1:0] w_src_d [DEPTH];
    logic [DEPTH-1:0] w_v_next;
    logic [CW-1:0]    w_count_next;
    logic             w_move;

    // Ready ripples back from the output: this is the DEPTH-long OR chain.
    always_comb begin
        logic t;
        w_take = '0;
        t = ~r_v[DEPTH-1] | bus.out_ready;
        w_take[DEPTH-1] = t;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            t = ~r_v[i] | t;
            w_take[i] = t;
        end
    end

    always_comb begin
        w_src_v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_src_d[i] = '0;
        end
        w_src_v[0] = bus.in_valid;
        w_src_d[0] = bus.in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_v[i] = r_v[i-1];
            w_src_d[i] = r_d[i-1];
        end
    end

    always_comb begin
        w_move       = en & ~flush;
        w_v_next     = '0;
        w_count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_v_next[i] = w_take[i] ? w_src_v[i] : r_v[i];
        end
        if (flush) begin
            w_v_next = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_count_next = w_count_next + CW'(w_v_next[i]);
        end
    end

    // Data registers only load real words, so a drained output keeps its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v     <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else if (en) begin
            r_v     <= w_v_next;
            r_count <= w_count_next;
            if (!flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_take[i] && w_src_v[i]) begin
                        r_d[i] <= w_src_d[i];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = w_take[0] & w_move & ~reset;
    assign bus.out_valid = r_v[DEPTH-1] & w_move & ~reset;
    assign bus.out_data  = r_d[DEPTH-1];
    assign count         = r_count;

endmodule
